// File: rtl/jbi_ok_pkg.sv
// Shared types and helpers for the JBI AOK/DOK grant scheduler.
package jbi_ok_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int GAP_CNT_W = 4;

  // Next round-robin pointer with an explicit wrap at n (n need not be a power of two).
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/jbi_ok_rr_pick.sv
// Combinational round-robin first-one finder: first set pend bit at or above rr_ptr, wrapping.
module jbi_ok_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  pick_id,
  output logic             pick_vld
);

  int               idx;
  logic [N_REQ-1:0] sh;

  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    sh       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sh = pend >> idx;
      if (!pick_vld && sh[0]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/jbi_ok_grant_sched.sv
// Round-robin grant scheduler over a bank of set/clear pending flags, with a
// programmable idle gap after every accepted grant.
module jbi_ok_grant_sched
  import jbi_ok_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [N_REQ-1:0] req_set,
  input  logic [N_REQ-1:0] req_clr,
  input  logic             arb_en,
  input  logic             gnt_rdy,
  output logic             gnt_vld,
  output logic [ID_W-1:0]  gnt_id,
  output logic [N_REQ-1:0] pend,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  // Handshake: a grant transfers on any cycle with gnt_vld & gnt_rdy. While
  // gnt_vld is high gnt_id is stable; the grant is only dropped without a
  // transfer when its own pending flag is cancelled (withdraw).

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic [N_REQ-1:0]       pend_q, pend_d;
  logic                   gnt_vld_q;
  logic                   busy_q;

  logic                   accept;
  logic [N_REQ-1:0]       acc_mask;
  logic [N_REQ-1:0]       clr_sh, set_sh;
  logic                   withdraw;
  logic [ID_W-1:0]        pick_id;
  logic                   pick_vld;

  assign accept   = gnt_vld_q & gnt_rdy;
  assign acc_mask = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_id_q) : '0;
  assign clr_sh   = req_clr >> gnt_id_q;
  assign set_sh   = req_set >> gnt_id_q;
  assign withdraw = clr_sh[0] & ~set_sh[0];

  // Set dominates; a same-cycle set re-arms a flag that is being accepted.
  assign pend_d = req_set | (pend_q & ~req_clr & ~acc_mask);

  jbi_ok_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .pend     (pend_q),
    .rr_ptr   (rr_ptr_q),
    .pick_id  (pick_id),
    .pick_vld (pick_vld)
  );

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    gap_d    = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && pick_vld) begin
          state_d  = ST_GRANT;
          gnt_id_d = pick_id;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          rr_ptr_d = ID_W'(rr_next(int'(gnt_id_q), N_REQ));
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (withdraw) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= ST_IDLE;
      gnt_id_q  <= '0;
      rr_ptr_q  <= '0;
      gap_q     <= '0;
      pend_q    <= '0;
      gnt_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      rr_ptr_q  <= rr_ptr_d;
      gap_q     <= gap_d;
      pend_q    <= pend_d;
      gnt_vld_q <= (state_d == ST_GRANT);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign gnt_vld   = gnt_vld_q;
  assign gnt_id    = gnt_id_q;
  assign pend      = pend_q;
  assign busy      = busy_q;
  assign fsm_state = state_q;

endmodule
